imem_fetch: RTL and testbench

IMEM_FETCH -- requirements
Module: imem_fetch

---
 rtl/imem_fetch.sv | 134 +++++++++++++
 tb/tb_imem_fetch.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch.sv
// rtl/imem_fetch.sv - byte-serial instruction fetch from an 8-bit RAM
//
// Purpose: on an instruction-cache miss, reads four consecutive bytes
// starting at pc_in from a byte-wide RAM with one-cycle read latency,
// assembles them little-endian into a 32-bit word and pulses inst_rdy
// for one enabled cycle.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   rdy        global enable; 0 freezes all state and outputs
//   inst_miss  fetch request level, held until inst_rdy is seen
//   pc_in      byte address of the requested instruction
//   flush      abort request (honoured only with IMEM_FLUSH_EN)
//   inst_rdy   completion pulse
//   inst_data  assembled instruction word
//   mem_din    RAM read byte (returns byte for the previous cycle's mem_a)
//   mem_a      RAM byte address (registered)
//   mem_wr     RAM write enable, constant 0
//
// Configuration: define IMEM_FLUSH_EN to enable the flush abort.

module imem_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        inst_miss,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        inst_rdy,
  output logic [31:0] inst_data,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;          // READ edges taken since acceptance
  logic [23:0] word, word_n;        // lanes 0..2 while lane 3 is pending
  logic [31:0] mem_a_n;
  logic [31:0] inst_data_n;
  logic        inst_rdy_n;
  logic        flush_act;

`ifdef IMEM_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = flush & 1'b0;
`endif

  assign mem_wr = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      word      <= 24'd0;
      mem_a     <= 32'd0;
      inst_data <= 32'd0;
      inst_rdy  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      word      <= word_n;
      mem_a     <= mem_a_n;
      inst_data <= inst_data_n;
      inst_rdy  <= inst_rdy_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    word_n      = word;
    mem_a_n     = mem_a;
    inst_data_n = inst_data;
    inst_rdy_n  = inst_rdy;

    if (rdy) begin
      inst_rdy_n = 1'b0;
      case (state)
        IDLE: begin
          if (inst_miss) begin
            mem_a_n = pc_in;
            cnt_n   = 3'd0;
            state_n = READ;
          end
        end
        READ: begin
          // Address leads the data by one READ edge: addresses pc+1..pc+3
          // are issued on edges 0..2, lanes 0..3 are captured on edges 1..4.
          if (cnt < 3'd3) begin
            mem_a_n = mem_a + 32'd1;
          end
          case (cnt)
            3'd1: word_n[7:0]   = mem_din;
            3'd2: word_n[15:8]  = mem_din;
            3'd3: word_n[23:16] = mem_din;
            default: ;
          endcase
          if (cnt == 3'd4) begin
            inst_data_n = {mem_din, word[23:0]};
            inst_rdy_n  = 1'b1;
            state_n     = DONE;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end
        DONE: begin
          // inst_miss is deliberately not looked at here so a request still
          // held from the finished fetch is not accepted a second time.
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase

      // Abort overrides acceptance and lane-3 completion on the same edge.
      if (flush_act) begin
        state_n     = IDLE;
        cnt_n       = 3'd0;
        inst_rdy_n  = 1'b0;
        inst_data_n = inst_data;
        mem_a_n     = mem_a;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch.sv
// tb/tb_imem_fetch.sv - scoreboard testbench for imem_fetch

module tb_imem_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        inst_miss;
  logic [31:0] pc_in;
  logic        flush;
  logic        inst_rdy;
  logic [31:0] inst_data;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic        mem_wr;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  imem_fetch dut (
    .clk(clk), .rst(rst), .rdy(rdy), .inst_miss(inst_miss), .pc_in(pc_in),
    .flush(flush), .inst_rdy(inst_rdy), .inst_data(inst_data),
    .mem_din(mem_din), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  // RAM contents: 0x100..0x103 hold an addi; elsewhere byte = addr[7:0]^0x5A
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    case (a)
      32'h100: ram_byte = 8'h13;
      32'h101: ram_byte = 8'h00;
      32'h102: ram_byte = 8'h50;
      32'h103: ram_byte = 8'h00;
      default: ram_byte = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // One-cycle-latency RAM, stalled along with the rest of the system by rdy.
  always @(posedge clk) begin
    if (rdy) mem_din <= ram_byte(mem_a);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each new inst_rdy pulse.
  logic prev_rdy_out = 1'b0;
  logic prev_hi_en = 1'b0;
  always @(negedge clk) begin
    if (inst_rdy && !prev_rdy_out) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {31'd0, inst_rdy}, 32'd0);
      end else begin
        check("inst_data", inst_data, sb.pop_front());
      end
      check("mem_wr", {31'd0, mem_wr}, 32'd0);
    end
    if (inst_rdy && rdy) begin
      check("pulse_width", {31'd0, prev_hi_en}, 32'd0);
    end
    prev_rdy_out = inst_rdy;
    prev_hi_en   = inst_rdy && rdy && rst;
  end

  // Full fetch with address sequence and exact latency checks.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] exp);
    @(negedge clk);
    inst_miss = 1'b1;
    pc_in     = pc;
    sb.push_back(exp);
    @(posedge clk); #1;
    check("mem_a_accept", mem_a, pc);
    pc_in = ~pc;  // ignored after acceptance
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check("mem_a_seq", mem_a, pc + k);
    end
    @(posedge clk); #1;
    check("mem_a_hold", mem_a, pc + 32'd3);
    check("no_early_rdy", {31'd0, inst_rdy}, 32'd0);
    @(posedge clk); #1;
    check("latency", {31'd0, inst_rdy}, 32'd1);
    @(posedge clk); #1;  // DONE edge, inst_miss still high
    check("rdy_drop", {31'd0, inst_rdy}, 32'd0);
    check("data_hold", inst_data, exp);
    inst_miss = 1'b0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; inst_miss = 1'b0; pc_in = 32'd0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_inst_rdy", {31'd0, inst_rdy}, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Basic fetch; inst_miss held through DONE then dropped.
    fetch(32'h100, 32'h00500013);
    repeat (8) @(posedge clk);

    // Address wrap.
    fetch(32'hFFFFFFFE, 32'h5B5AA5A4);
    repeat (2) @(posedge clk);

    // Stall three cycles mid-READ.
    @(negedge clk);
    inst_miss = 1'b1; pc_in = 32'h200; sb.push_back(32'h59585B5A);
    @(posedge clk); #1; check("stall_accept", mem_a, 32'h200);
    @(posedge clk); #1; check("stall_a1", mem_a, 32'h201);
    @(posedge clk); #1; check("stall_a2", mem_a, 32'h202);
    rdy = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_frozen", mem_a, 32'h202);
      check("stall_no_rdy", {31'd0, inst_rdy}, 32'd0);
    end
    rdy = 1'b1;
    @(posedge clk); #1; check("stall_a3", mem_a, 32'h203);
    @(posedge clk); #1; check("stall_no_rdy2", {31'd0, inst_rdy}, 32'd0);
    @(posedge clk); #1; check("stall_latency", {31'd0, inst_rdy}, 32'd1);
    @(posedge clk); #1; check("stall_drop", {31'd0, inst_rdy}, 32'd0);
    inst_miss = 1'b0;
    repeat (2) @(posedge clk);

    // Reset on the third READ edge aborts the fetch.
    @(negedge clk);
    inst_miss = 1'b1; pc_in = 32'h100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_mem_a", mem_a, 32'd0);
    check("abort_inst_rdy", {31'd0, inst_rdy}, 32'd0);
    check("abort_inst_data", inst_data, 32'd0);
    inst_miss = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (8) @(posedge clk);
    fetch(32'h100, 32'h00500013);
    repeat (2) @(posedge clk);

    // Flush on the lane-3 edge.
    @(negedge clk);
    inst_miss = 1'b1; pc_in = 32'h200;
`ifndef IMEM_FLUSH_EN
    sb.push_back(32'h59585B5A);
`endif
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    inst_miss = 1'b0;
`ifdef IMEM_FLUSH_EN
    check("flush_no_rdy", {31'd0, inst_rdy}, 32'd0);
    check("flush_data_hold", inst_data, 32'h00500013);
`else
    check("noflush_rdy", {31'd0, inst_rdy}, 32'd1);
    check("noflush_data", inst_data, 32'h59585B5A);
`endif
    @(posedge clk); #1;
    check("flush_after", {31'd0, inst_rdy}, 32'd0);
    repeat (4) @(posedge clk);

    fetch(32'h300, 32'h59585B5A);
    repeat (6) @(posedge clk);
    check("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
